// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-trial reaction-timer sequencer.
package reaction_pkg;

  typedef enum logic [7:0] {
    IDLE    = 8'b0000_0001,
    ARM     = 8'b0000_0010,
    WAIT    = 8'b0000_0100,
    TIME    = 8'b0000_1000,
    CAPTURE = 8'b0001_0000,
    GAP     = 8'b0010_0000,
    SUMMARY = 8'b0100_0000,
    FAULT   = 8'b1000_0000
  } state_t;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_t;

  localparam logic [3:0] DIG_BLANK  = 4'hF;
  localparam logic [3:0] DIG_BAD    = 4'h9;
  localparam logic [3:0] DIG_IDLE_A = 4'hA;
  localparam logic [3:0] DIG_IDLE_5 = 4'h5;

  localparam bcd_t BCD_TIMEOUT = '{d3: 4'd1, d2: 4'd0, d1: 4'd0, d0: 4'd0};
  localparam bcd_t BCD_MAX     = '{d3: 4'd9, d2: 4'd9, d1: 4'd9, d0: 4'd9};

  // Strict less-than on 4-digit BCD, most significant digit decides first.
  function automatic logic bcd_lt(input bcd_t a, input bcd_t b);
    if (a.d3 != b.d3) return a.d3 < b.d3;
    if (a.d2 != b.d2) return a.d2 < b.d2;
    if (a.d1 != b.d1) return a.d1 < b.d1;
    return a.d0 < b.d0;
  endfunction

endpackage

// File: rtl/trial_delay_timer.sv
// Loadable down counter that parks at zero; shared by the pre-stimulus wait
// and the between-trial gap.
module trial_delay_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (load)                 count <= load_val;
    else if (en && count != '0)    count <= count - W'(1);
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/reaction_trial_sched.sv
// Multi-trial reaction-timer sequencer: random delay, stopwatch control,
// per-trial capture, best-time tracking and display selection.
module reaction_trial_sched
  import reaction_pkg::*;
#(
  parameter int unsigned N_TRIALS   = 4,
  parameter int unsigned DLY_UNIT   = 100_000_000,
  parameter int unsigned MIN_DLY    = 1,
  parameter int unsigned GAP_CYCLES = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  input  logic [3:0] rand_val,
  input  logic [3:0] sw_d0,
  input  logic [3:0] sw_d1,
  input  logic [3:0] sw_d2,
  input  logic [3:0] sw_d3,
  output logic       sw_go,
  output logic       sw_clr,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       ltr_flag,
  output logic       led0,
  output logic       false_start,
  output logic       done,
  output logic [2:0] trial_idx
);

  localparam int unsigned DLY_W = $clog2((15 + MIN_DLY) * DLY_UNIT);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES);
  localparam int unsigned CNT_W = (DLY_W > GAP_W) ? DLY_W : GAP_W;

  state_t           state, state_next;
  bcd_t             sw_now, sw_q, best, last, disp;
  logic [2:0]       idx_inc;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0] tmr_val, dly_load;

  assign sw_now   = {sw_d3, sw_d2, sw_d1, sw_d0};
  assign idx_inc  = trial_idx + 3'd1;
  assign dly_load = (CNT_W'(rand_val) + CNT_W'(MIN_DLY)) * CNT_W'(DLY_UNIT) - CNT_W'(1);

  trial_delay_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Session data; the display copy of the stopwatch keeps outputs register-fed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trial_idx <= '0;
      best      <= BCD_MAX;
      last      <= '0;
      sw_q      <= '0;
    end else begin
      sw_q <= sw_now;
      if (state == IDLE && state_next == ARM) begin
        trial_idx <= '0;
        best      <= BCD_MAX;
      end else if (state == CAPTURE && state_next != IDLE) begin
        last      <= sw_now;
        trial_idx <= idx_inc;
        if (bcd_lt(sw_now, best)) best <= sw_now;
      end
    end
  end

  always_comb begin
    state_next  = state;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    tmr_val     = dly_load;
    disp        = {DIG_BLANK, DIG_BLANK, DIG_BLANK, DIG_BLANK};
    ltr_flag    = 1'b0;
    sw_go       = 1'b0;
    sw_clr      = 1'b0;
    led0        = 1'b0;
    false_start = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        disp     = {DIG_BLANK, DIG_BLANK, DIG_IDLE_5, DIG_IDLE_A};
        ltr_flag = 1'b1;
        sw_clr   = 1'b1;
        if (start_btn) state_next = ARM;
      end
      ARM: begin
        sw_clr     = 1'b1;
        tmr_load   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (stop_btn)      state_next = FAULT;
        else if (tmr_zero) state_next = TIME;
      end
      TIME: begin
        disp  = sw_q;
        sw_go = 1'b1;
        led0  = 1'b1;
        if (stop_btn || sw_now == BCD_TIMEOUT) state_next = CAPTURE;
      end
      CAPTURE: begin
        disp = sw_q;
        led0 = 1'b1;
        if (idx_inc == 3'(N_TRIALS)) begin
          state_next = SUMMARY;
        end else begin
          state_next = GAP;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        disp   = last;
        tmr_en = 1'b1;
        if (tmr_zero) state_next = ARM;
      end
      SUMMARY: begin
        disp = best;
        done = 1'b1;
      end
      FAULT: begin
        disp        = {DIG_BAD, DIG_BAD, DIG_BAD, DIG_BAD};
        false_start = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Clear aborts the session from anywhere but idle, ahead of any stop press.
    if (clear_btn && state != IDLE) state_next = IDLE;
  end

  assign digit0 = disp.d0;
  assign digit1 = disp.d1;
  assign digit2 = disp.d2;
  assign digit3 = disp.d3;

endmodule

// File: tb/tb_reaction_trial_sched.sv
// Directed bench for reaction_trial_sched: stimulus queues cycle-stamped
// expected output words, a negedge monitor pops and compares them.
module tb_reaction_trial_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0, stop_btn = 1'b0, clear_btn = 1'b0;
  logic [3:0] rand_val = 4'd0;
  logic [3:0] sw_d0 = 4'd0, sw_d1 = 4'd0, sw_d2 = 4'd0, sw_d3 = 4'd0;
  logic       sw_go, sw_clr, ltr_flag, led0, false_start, done;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [2:0] trial_idx;
  logic [24:0] outs;

  typedef struct {
    int          cyc;
    string       name;
    logic [24:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  reaction_trial_sched #(
    .N_TRIALS(2), .DLY_UNIT(4), .MIN_DLY(1), .GAP_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .rand_val(rand_val),
    .sw_d0(sw_d0), .sw_d1(sw_d1), .sw_d2(sw_d2), .sw_d3(sw_d3),
    .sw_go(sw_go), .sw_clr(sw_clr),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .ltr_flag(ltr_flag), .led0(led0), .false_start(false_start),
    .done(done), .trial_idx(trial_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign outs = {digit3, digit2, digit1, digit0,
                 ltr_flag, led0, sw_go, sw_clr, false_start, done, trial_idx};

  function automatic logic [24:0] mk(input logic [15:0] d, input logic ltr, input logic led,
                                     input logic go, input logic clr, input logic fs,
                                     input logic dn, input logic [2:0] t);
    return {d, ltr, led, go, clr, fs, dn, t};
  endfunction

  function automatic logic [24:0] o_idle(input logic [2:0] t);   return mk(16'hFF5A, 1, 0, 0, 1, 0, 0, t); endfunction
  function automatic logic [24:0] o_arm(input logic [2:0] t);    return mk(16'hFFFF, 0, 0, 0, 1, 0, 0, t); endfunction
  function automatic logic [24:0] o_wait(input logic [2:0] t);   return mk(16'hFFFF, 0, 0, 0, 0, 0, 0, t); endfunction
  function automatic logic [24:0] o_fault(input logic [2:0] t);  return mk(16'h9999, 0, 0, 0, 0, 1, 0, t); endfunction
  function automatic logic [24:0] o_time(input logic [15:0] s, input logic [2:0] t); return mk(s, 0, 1, 1, 0, 0, 0, t); endfunction
  function automatic logic [24:0] o_gap(input logic [15:0] l, input logic [2:0] t);  return mk(l, 0, 0, 0, 0, 0, 0, t); endfunction
  function automatic logic [24:0] o_sum(input logic [15:0] b, input logic [2:0] t);  return mk(b, 0, 0, 0, 0, 0, 1, t); endfunction

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (outs !== e.v) begin
        errors++;
        $display("FAIL %s @%0d: got %h required %h", e.name, cyc, outs, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int d, input logic [24:0] v, input string n);
    exp_t e;
    e.cyc  = cyc + d;
    e.v    = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic set_sw(input logic [15:0] v);
    {sw_d3, sw_d2, sw_d1, sw_d0} = v;
  endtask

  task automatic press_start(input logic [2:0] t_after);
    start_btn = 1'b1;
    exp_at(1, o_arm(t_after), "start_to_arm");
    tick();
    start_btn = 1'b0;
  endtask

  task automatic press_clear(input logic [2:0] t);
    clear_btn = 1'b1;
    exp_at(1, o_idle(t), "clear_to_idle");
    tick();
    clear_btn = 1'b0;
  endtask

  // Entered while in ARM; runs one trial stopped by stop_btn at reading sv.
  task automatic do_trial(input logic [15:0] sv, input logic [3:0] rv, input logic [2:0] t,
                          input logic last_trial, input logic [15:0] best_exp);
    int len;
    len = (int'(rv) + 1) * 4;
    rand_val = rv;
    set_sw(sv);
    exp_at(1, o_wait(t), "wait_first");
    exp_at(len, o_wait(t), "wait_last");
    exp_at(len + 1, o_time(sv, t), "time_entry");
    repeat (len + 1) tick();
    stop_btn = 1'b1;
    tick();
    stop_btn = 1'b0;
    if (!last_trial) begin
      exp_at(1, o_gap(sv, 3'(t + 1)), "gap_first");
      exp_at(8, o_gap(sv, 3'(t + 1)), "gap_last");
      exp_at(9, o_arm(3'(t + 1)), "gap_to_arm");
      tick();
      start_btn = 1'b1;
      stop_btn  = 1'b1;
      tick();
      start_btn = 1'b0;
      stop_btn  = 1'b0;
      repeat (7) tick();
    end else begin
      exp_at(1, o_sum(best_exp, 3'(t + 1)), "summary");
      tick();
      start_btn = 1'b1;
      stop_btn  = 1'b1;
      exp_at(1, o_sum(best_exp, 3'(t + 1)), "summary_hold");
      tick();
      start_btn = 1'b0;
      stop_btn  = 1'b0;
    end
  endtask

  initial begin
    tick();
    exp_at(0, o_idle(0), "in_reset");
    tick();
    rst = 1'b0;
    exp_at(0, o_idle(0), "idle_after_reset");
    tick();

    // Session 1: 0253 then 0187, best is the second result.
    press_start(0);
    do_trial(16'h0253, 4'd2, 3'd0, 1'b0, 16'h0000);
    do_trial(16'h0187, 4'd0, 3'd1, 1'b1, 16'h0187);

    // Session 2: 0253 then 0300, best stays at the first result.
    press_clear(3'd2);
    clear_btn = 1'b1;
    exp_at(1, o_idle(2), "clear_in_idle");
    tick();
    clear_btn = 1'b0;
    press_start(0);
    do_trial(16'h0253, 4'd1, 3'd0, 1'b0, 16'h0000);
    do_trial(16'h0300, 4'd3, 3'd1, 1'b1, 16'h0253);

    // False start in the middle of the wait; start is ignored in fault.
    press_clear(3'd2);
    press_start(0);
    rand_val = 4'd5;
    exp_at(1, o_wait(0), "wait_fs");
    repeat (3) tick();
    stop_btn = 1'b1;
    exp_at(1, o_fault(0), "fault_mid_wait");
    tick();
    stop_btn  = 1'b0;
    start_btn = 1'b1;
    exp_at(1, o_fault(0), "fault_hold");
    tick();
    start_btn = 1'b0;
    press_clear(3'd0);

    // False start on the expiry cycle of trial 2; trial count frozen at 1.
    press_start(0);
    do_trial(16'h0253, 4'd0, 3'd0, 1'b0, 16'h0000);
    rand_val = 4'd0;
    exp_at(1, o_wait(1), "wait2_first");
    exp_at(4, o_wait(1), "wait2_expiry");
    repeat (4) tick();
    stop_btn = 1'b1;
    exp_at(1, o_fault(1), "fault_on_expiry");
    tick();
    stop_btn = 1'b0;
    press_clear(3'd1);

    // Timeout at 1000, then clear beats stop in TIME.
    press_start(0);
    rand_val = 4'd0;
    set_sw(16'h0000);
    exp_at(5, o_time(16'h0000, 0), "time_zero");
    repeat (5) tick();
    repeat (3) tick();
    set_sw(16'h1000);
    exp_at(2, o_gap(16'h1000, 1), "timeout_gap");
    exp_at(10, o_arm(1), "timeout_to_arm");
    repeat (10) tick();
    rand_val = 4'd0;
    set_sw(16'h0042);
    exp_at(5, o_time(16'h0042, 1), "time_0042");
    repeat (5) tick();
    clear_btn = 1'b1;
    stop_btn  = 1'b1;
    exp_at(1, o_idle(1), "clear_beats_stop");
    tick();
    clear_btn = 1'b0;
    stop_btn  = 1'b0;

    // Asynchronous reset in the middle of TIME.
    set_sw(16'h0000);
    press_start(0);
    rand_val = 4'd0;
    exp_at(5, o_time(16'h0000, 0), "time_before_rst");
    repeat (5) tick();
    tick();
    #2;
    rst = 1'b1;
    exp_at(0, o_idle(0), "rst_async");
    tick();
    exp_at(0, o_idle(0), "rst_hold");
    rst = 1'b0;
    tick();
    exp_at(0, o_idle(0), "after_rst");
    repeat (3) tick();

    if (sb.size() != 0) begin
      $display("FAIL leftover: %0d expectations never reached, required 0", sb.size());
      checks += sb.size();
      errors += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
